// File: rtl/cnn_mac_pkg.sv
// Shared helpers for the conv-layer MAC blocks: tap counter sizing and saturation bounds.
// Latency: none (constant functions only).
// Backpressure: not applicable.
package cnn_mac_pkg;

  // Counter must be able to hold max_taps itself, hence the +1.
  function automatic int tap_cnt_w(input int max_taps);
    return $clog2(max_taps + 1);
  endfunction

  // Largest positive value representable in a signed out_w-bit result.
  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a signed out_w-bit result.
  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Signed A x B multiply, sign-extended to ACC_WIDTH, carried with valid/last through NUM_STAGE registers.
// Latency: NUM_STAGE cycles from input to out_vld.
// Backpressure: en=0 freezes every stage (data and sideband) in place.
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 32,
  parameter int NUM_STAGE = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in_vld,
  input  logic                        in_last,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic                        out_vld,
  output logic                        out_last,
  output logic signed [ACC_WIDTH-1:0] p
);

  logic signed [A_WIDTH+B_WIDTH-1:0] prod;
  logic [NUM_STAGE-1:0]              vld_d, vld_q;
  logic [NUM_STAGE-1:0]              last_d, last_q;
  logic signed [ACC_WIDTH-1:0]       p_d [NUM_STAGE];
  logic signed [ACC_WIDTH-1:0]       p_q [NUM_STAGE];

  // Full-width product; the size cast below sign-extends it into the accumulator width.
  assign prod = a * b;

  // Shift the chain by one stage when enabled, otherwise hold.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    for (int i = 0; i < NUM_STAGE; i++) p_d[i] = p_q[i];
    if (en) begin
      vld_d[0]  = in_vld;
      last_d[0] = in_last;
      p_d[0]    = ACC_WIDTH'(prod);
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_d[i]  = vld_q[i-1];
        last_d[i] = last_q[i-1];
        p_d[i]    = p_q[i-1];
      end
    end
  end

  // Stage registers; reset clears in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int i = 0; i < NUM_STAGE; i++) p_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      for (int i = 0; i < NUM_STAGE; i++) p_q[i] <= p_d[i];
    end
  end

  assign out_vld  = vld_q[NUM_STAGE-1];
  assign out_last = last_q[NUM_STAGE-1];
  assign p        = p_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe_s.sv
// Pipelined signed MAC: accumulates din0*din1 per window, emits (acc >>> FRAC_SHIFT) on the last beat.
// Latency: last beat accepted at cycle t -> out_valid at t+NUM_STAGE+1; 1 beat/cycle.
// Backpressure: out_valid && !out_ready stalls the whole pipe and drops in_ready. CNN_MAC_SAT_EN selects clamping.
module cnn_mac_pipe_s
  import cnn_mac_pkg::*;
#(
  parameter int A_WIDTH    = 14,
  parameter int B_WIDTH    = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 6,
  parameter int NUM_STAGE  = 2,
  parameter int MAX_TAPS   = 1024
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic signed [A_WIDTH-1:0]   din0,
  input  logic signed [B_WIDTH-1:0]   din1,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        ovf_err
);

  localparam int CNT_W = tap_cnt_w(MAX_TAPS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TAPS);

  logic                        stall;
  logic                        accept;
  logic                        t_vld;
  logic                        t_last;
  logic signed [ACC_WIDTH-1:0] t_p;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [OUT_WIDTH-1:0] scaled;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [OUT_WIDTH-1:0] dout_d, dout_q;
  logic                        out_vld_d, out_vld_q;
  logic [CNT_W-1:0]            cnt_d, cnt_q;
  logic                        ovf_d, ovf_q;

  // A held result that nobody takes freezes everything upstream.
  assign stall    = out_vld_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  cnn_mac_mul_pipe #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .NUM_STAGE(NUM_STAGE)
  ) u_mul (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .en      (!stall),
    .in_vld  (accept),
    .in_last (in_last),
    .a       (din0),
    .b       (din1),
    .out_vld (t_vld),
    .out_last(t_last),
    .p       (t_p)
  );

  // Wraps modulo 2^ACC_WIDTH by construction.
  assign sum = acc_q + t_p;

`ifdef CNN_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(OUT_WIDTH));
  logic signed [ACC_WIDTH-1:0] shifted;
  assign shifted = sum >>> FRAC_SHIFT;

  // Floor-scale then clamp into the signed output range.
  always_comb begin
    if (shifted > SAT_MAX)      scaled = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) scaled = SAT_MIN[OUT_WIDTH-1:0];
    else                        scaled = shifted[OUT_WIDTH-1:0];
  end
`else
  // Floor-scale then keep the low bits (two's-complement wrap).
  always_comb begin
    scaled = OUT_WIDTH'(sum >>> FRAC_SHIFT);
  end
`endif

  // Accumulate at the pipe tail, close windows into the output register, track window length.
  always_comb begin
    acc_d     = acc_q;
    dout_d    = dout_q;
    out_vld_d = out_vld_q && !out_ready;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    if (!stall && t_vld) begin
      if (t_last) begin
        acc_d     = '0;
        dout_d    = scaled;
        out_vld_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
    if (accept) begin
      // Counter parks at MAX_TAPS so any further beat in the same window keeps flagging.
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      if (in_last)              cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  // Accumulator, output and counter state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q     <= '0;
      dout_q    <= '0;
      out_vld_q <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      dout_q    <= dout_d;
      out_vld_q <= out_vld_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = out_vld_q;
  assign dout      = dout_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_cnn_mac_pipe_s.sv
// Directed scoreboard bench for cnn_mac_pipe_s (MAX_TAPS=4 so the overflow flag is reachable).
// Latency: checks out_valid three cycles after a single-beat window with default NUM_STAGE.
// Backpressure: exercises a 5-cycle out_ready drop with two results queued.
module tb_cnn_mac_pipe_s;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic signed [13:0] din0;
  logic signed [7:0]  din1;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] dout;
  logic               ovf_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;
  logic signed [15:0] exp_q[$];

  always #5 ap_clk = ~ap_clk;

  cnn_mac_pipe_s #(
    .A_WIDTH   (14),
    .B_WIDTH   (8),
    .ACC_WIDTH (32),
    .OUT_WIDTH (16),
    .FRAC_SHIFT(6),
    .NUM_STAGE (2),
    .MAX_TAPS  (4)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .din0     (din0),
    .din1     (din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .ovf_err  (ovf_err)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Present one beat for one clock; caller lowers in_valid afterwards.
  task automatic beat(input int a, input int b, input bit last);
    in_valid = 1'b1;
    din0     = 14'(a);
    din1     = 8'(b);
    in_last  = last;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) step();
  endtask

  // Monitor: every handshaken result is compared against the oldest expectation.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: dout %0d with nothing pending", dout);
      end else begin
        check("dout", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n0;
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    din0      = '0;
    din1      = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_in_ready", in_ready, 1);
    ap_rst_n = 1'b1;
    repeat (2) step();

    // 1: extremes, single beat, latency
    exp_q.push_back(16'sd16384);
    beat(-8192, -128, 1'b1);
    idle();
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("t1_latency", lat, 3);
    wait_drain();

    // 2: nine-beat window, exactly one result
    n0 = n_out;
    exp_q.push_back(16'sd42);
    for (int i = 0; i < 9; i++) beat(100, 3, i == 8);
    idle();
    wait_drain();
    repeat (4) step();
    check("t2_result_count", n_out - n0, 1);
    check("t2_ovf_after_9", ovf_err, 1);

    // 3: 64 beats of 8191*127, acc>>>6 = 1040257
`ifdef CNN_MAC_SAT_EN
    exp_q.push_back(16'sd32767);
`else
    exp_q.push_back(-16'sd8319);
`endif
    for (int i = 0; i < 64; i++) beat(8191, 127, i == 63);
    idle();
    wait_drain();

    // 4: backpressure with two queued single-beat windows
    out_ready = 1'b0;
    exp_q.push_back(16'sd10);
    exp_q.push_back(-16'sd20);
    beat(640, 1, 1'b1);
    beat(-1280, 1, 1'b1);
    idle();
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("t4_first_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready_low", in_ready, 0);
      check("t4_dout_held", dout, 10);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t4_no_bubble_valid", out_valid, 1);
    check("t4_second_dout", dout, -20);
    wait_drain();

    // 5: reset mid-window discards the partial sum
    for (int i = 0; i < 3; i++) beat(50, 2, 1'b0);
    idle();
    ap_rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_dout", dout, 0);
    check("t5_ovf", ovf_err, 0);
    repeat (2) step();
    ap_rst_n = 1'b1;
    repeat (2) step();
    exp_q.push_back(-16'sd1);
    beat(2, -3, 1'b1);
    idle();
    wait_drain();

    // 6: overflow after MAX_TAPS=4 beats, sticky until reset
    for (int i = 0; i < 4; i++) beat(1, 1, 1'b0);
    idle();
    repeat (4) step();
    check("t6_ovf_after_4", ovf_err, 0);
    beat(1, 1, 1'b0);
    idle();
    repeat (4) step();
    check("t6_ovf_after_5", ovf_err, 1);
    beat(1, 1, 1'b0);
    idle();
    repeat (10) step();
    check("t6_ovf_sticky", ovf_err, 1);
    ap_rst_n = 1'b0;
    #1;
    check("t6_ovf_reset", ovf_err, 0);
    step();
    ap_rst_n = 1'b1;
    repeat (3) step();
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
